// File: rtl/aes_ctl_pkg.sv
// Shared types and constants for the AES word loader.
package aes_ctl_pkg;

  localparam int WORD_W        = 32;
  localparam int BLK_W         = 128;
  localparam int WORDS_PER_BLK = 4;

  localparam logic KEY_WORD  = 1'b1;
  localparam logic TEXT_WORD = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BUSY
  } state_t;

endpackage

// File: rtl/aes_word_loader_if.sv
// 32-bit word stream into the loader; s_is_key travels with s_data.
interface aes_word_loader_if;
  import aes_ctl_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_is_key;

  modport master (output s_valid, output s_data, output s_is_key, input s_ready);
  modport slave  (input s_valid, input s_data, input s_is_key, output s_ready);

endinterface

// File: rtl/aes_word_pack.sv
// Packs four 32-bit words MSW-first into a 128-bit staging block.
module aes_word_pack
  import aes_ctl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              clr_full,
  input  logic [WORD_W-1:0] data,
  output logic [BLK_W-1:0]  blk,
  output logic [1:0]        cnt,
  output logic              full,
  output logic              first
);

  // Next push starts a new group.
  assign first = (cnt == 2'd0);

  // Word counter and group-complete flag; completion wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      full <= 1'b0;
    end else begin
      if (push) begin
        cnt <= cnt + 2'd1;
      end
      if (push && (cnt == 2'(WORDS_PER_BLK - 1))) begin
        full <= 1'b1;
      end else if (clr_full) begin
        full <= 1'b0;
      end
    end
  end

  // Staging data: first word of a group lands in the top slice.
  always_ff @(posedge clk) begin
    if (push) begin
      case (cnt)
        2'd0:    blk[BLK_W-1          -: WORD_W] <= data;
        2'd1:    blk[BLK_W-1-WORD_W   -: WORD_W] <= data;
        2'd2:    blk[BLK_W-1-2*WORD_W -: WORD_W] <= data;
        default: blk[WORD_W-1:0]                 <= data;
      endcase
    end
  end

endmodule

// File: rtl/aes_word_loader.sv
// Feeds the AES core: stages key/text blocks from a word stream, issues a
// one-cycle ld, waits for done with a watchdog, and counts completed blocks.
module aes_word_loader
  import aes_ctl_pkg::*;
#(
  parameter int DONE_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_word_loader_if.slave       s,
  input  logic                   done_i,
  output logic                   ld_o,
  output logic [BLK_W-1:0]       key_o,
  output logic [BLK_W-1:0]       text_o,
  output logic                   busy,
  output logic                   key_valid,
  output logic                   err,
  output logic [CNT_W-1:0]       blk_cnt
);

  localparam int TMR_W = $clog2(DONE_TIMEOUT);

  state_t             state;
  logic [TMR_W-1:0]   timer;

  logic               key_push;
  logic               text_push;
  logic               start;
  logic [BLK_W-1:0]   key_stage;
  logic [BLK_W-1:0]   text_stage;
  logic [1:0]         key_cnt;
  logic [1:0]         text_cnt;
  logic               key_first;
  logic               text_first;
  logic               text_full;
  logic               unused_pack;

  // Key words are never back-pressured; text stalls only while a block is staged.
  assign s.s_ready = !((s.s_is_key == TEXT_WORD) && text_full);
  assign key_push  = s.s_valid && (s.s_is_key == KEY_WORD);
  assign text_push = s.s_valid && s.s_ready && (s.s_is_key == TEXT_WORD);
  assign start     = (state == IDLE) && text_full && key_valid;

  assign unused_pack = ^{key_cnt, text_cnt, text_first};

  aes_word_pack u_key_pack (
    .clk      (clk),
    .rst      (rst),
    .push     (key_push),
    .clr_full (key_push && key_first),
    .data     (s.s_data),
    .blk      (key_stage),
    .cnt      (key_cnt),
    .full     (key_valid),
    .first    (key_first)
  );

  aes_word_pack u_text_pack (
    .clk      (clk),
    .rst      (rst),
    .push     (text_push),
    .clr_full (start),
    .data     (s.s_data),
    .blk      (text_stage),
    .cnt      (text_cnt),
    .full     (text_full),
    .first    (text_first)
  );

  // Load/busy sequencer with watchdog; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      ld_o    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      key_o   <= '0;
      text_o  <= '0;
      blk_cnt <= '0;
    end else begin
      ld_o <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            ld_o   <= 1'b1;
            busy   <= 1'b1;
            key_o  <= key_stage;
            text_o <= text_stage;
          end
        end
        LOAD: begin
          state <= BUSY;
          timer <= '0;
        end
        BUSY: begin
          if (done_i) begin
            state   <= IDLE;
            busy    <= 1'b0;
            blk_cnt <= blk_cnt + CNT_W'(1);
          end else if (timer == TMR_W'(DONE_TIMEOUT - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_word_loader.md
Name: aes_word_loader

Overview:
- Upstream feeder for the AES core top-level.
- Accepts a 32-bit word stream under valid/ready and assembles 128-bit key and text blocks.
- Issues a single-cycle ld with stable key/text, then waits for done from the core.
- Double-buffers: while the core is busy, the next key and text are staged so back-to-back blocks incur minimal gap. A watchdog recovers from a missing done.

Parameters:
- DONE_TIMEOUT, 64, max BUSY cycles waiting for done_i before abort (must be >= 16)
- CNT_W, 16, width of the completed-block counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_valid  in  1  word valid
- s_ready  out  1  word accepted when s_valid && s_ready
- s_data  in  32  word payload
- s_is_key  in  1  1 = key word, 0 = text word; sampled with s_data
- done_i  in  1  completion pulse from AES core
- ld_o  out  1  load pulse to AES core
- key_o  out  128  active key to core
- text_o  out  128  active text to core
- busy  out  1  high in LOAD and BUSY states
- key_valid  out  1  staged key complete
- err  out  1  one-cycle pulse on timeout abort
- blk_cnt  out  CNT_W  blocks completed by done, wraps

Behaviour:
- Reset (sync, active-high):
  - state = IDLE; both word counters = 0; text_full = 0; key_valid = 0.
  - ld_o, err, busy, key_o, text_o, blk_cnt all 0.
  - Reset mid-operation aborts any in-flight block with no err pulse. ld_o is 0 from the first cycle after the reset edge.
- Word packing:
  - First word of a group lands in [127:96], the fourth in [31:0].
  - Key and text use independent 2-bit counters, so interleaving key and text words is legal.
- Key staging:
  - The first key word of a new group clears key_valid.
  - The fourth key word sets key_valid.
  - Key words are always accepted, including during BUSY; staging never disturbs key_o.
- Text staging:
  - The fourth text word sets text_full.
  - text_full clears on the IDLE->LOAD transfer.
- s_ready = !(~s_is_key && text_full). This is a combinational path from s_is_key, and is the permitted exception. A held word (valid && !ready) must stay stable; the bench checks this as a protocol assertion.
- State machine:
  - IDLE -> LOAD when text_full && key_valid. On that edge: key_o <= key_stage, text_o <= text_stage, text_full <= 0.
  - LOAD: ld_o = 1 for exactly one cycle -> BUSY.
  - BUSY: timer counts from 0.
    - done_i -> IDLE, blk_cnt++.
    - Else, timer == DONE_TIMEOUT-1 -> IDLE, err = 1 for one cycle, blk_cnt unchanged.
    - done_i in the same cycle as timeout: done wins, no err.
  - done_i in IDLE or LOAD is ignored.
- Latency and throughput:
  - Last word accepted in cycle N (key already valid, IDLE) -> ld_o high in cycle N+2.
  - done_i in cycle M with text staged -> next ld_o in cycle M+2.
- key_o and text_o are held stable from LOAD until the next LOAD; timeout does not clear them.
- A key group partially complete at LOAD time is not used: LOAD requires key_valid.
- blk_cnt wraps from all-ones to 0.

Decomposition:
- Package aes_ctl_pkg:
  - state enum {IDLE, LOAD, BUSY}
  - WORD_W = 32, BLK_W = 128, WORDS_PER_BLK = 4
  - localparams KEY_WORD = 1'b1, TEXT_WORD = 1'b0
- Sub-module aes_word_pack:
  - Ports: clk, rst, push, clr_full, data[31:0] -> blk[127:0], cnt[1:0], full, first.
  - Instantiated twice, once for key and once for text.

Test Plan:
- FIPS-197 load: key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then text 00112233 .. ccddeeff. Expect ld_o one cycle, exactly 2 cycles after the last word; key_o = 000102030405060708090a0b0c0d0e0f; text_o = 00112233445566778899aabbccddeeff; busy high until done_i.
- Prefetch: during BUSY, send 4 text words (11111111 x4). Expect all accepted; a 5th text word stalls (s_ready=0); done_i at cycle M gives ld_o at M+2 with text_o = 1111...1111 and key_o unchanged.
- Key change in flight: during BUSY, send a new key (ffffffff x4). Expect key_o unchanged until the next LOAD; key_valid drops on word 1 and rises on word 4; the next ld_o carries the all-ones key.
- Timeout: withhold done_i. Expect err pulse in BUSY cycle 64, return to IDLE, blk_cnt unchanged. With done_i coincident on cycle 64: no err, blk_cnt+1.
- Interleave and no-key: alternate text/key words (T0 K0 T1 K1 ...). Expect correct packing in both blocks. With text complete and no key, no ld_o; it fires 2 cycles after the 4th key word.
- Reset mid-BUSY and wrap: rst in BUSY gives all outputs 0 next cycle and later done_i ignored. With blk_cnt preset to 0xffff via 65535 runs or force, one more done gives blk_cnt = 0x0000.
